wb_arb: RTL
===========

# wb_arb

Write-back arbiter sitting directly downstream of the functional units. It buffers each FU's result in a small per-source FIFO and grants the buffered results onto the `NR_WB_PORTS` register-file write-back ports with round-robin fairness. For every result it writes back it emits the matching ROB completion. This lets FUs whose latency exceeds one cycle, or whose results collide in the same cycle, share write-back ports without dropping results.

## Interface
Parameters:
- `NB_SRC`, default `3`: number of FU result sources.
- `DEPTH`, default `2`: entries per source FIFO; must be ≥1.
- `NR_PORTS`, default `NR_WB_PORTS`: write-back ports driven; must satisfy 1 ≤ `NR_PORTS` ≤ `NB_SRC`.

Ports:
- `clk`  in  1: clock; all state updates on rising edge.
- `rstn`  in  1: reset; asynchronous, active-low.
- `flush_i`  in  1: synchronous flush; empties all FIFOs.
- `src_i[NB_SRC]`  in  `fu_output_t`: FU results.
- `src_valid_i`  in  `NB_SRC`: per-source valid.
- `src_ready_o`  out  `NB_SRC`: per-source ready; a result is accepted when valid && ready at the edge.
- `wb_o[NR_PORTS]`  out  `fu_output_t`: write-back data.
- `wb_valid_o`  out  `NR_PORTS`: write-back valid; no back-pressure, so the consumer always accepts.
- `completion_o[NR_PORTS]`  out  `completion_port_t`:
  - `.id` = `wb_o[p].id`
  - `.valid` = `wb_valid_o[p]`

## Operation
- Each source owns a FIFO of `DEPTH` entries, with read and write pointers plus a count of width `$clog2(DEPTH+1)`.
- Pointers wrap modulo `DEPTH`; `DEPTH` is not required to be a power of two.
- Readiness: `src_ready_o[s]` = `count[s] < DEPTH`. A full FIFO does not accept in the same cycle it pops; there is no pass-through.
- Head visibility: the head of a non-empty FIFO is a request. The entry written at edge N is first requestable in cycle N+1.
- Arbitration (combinational, each cycle):
  - Scan sources starting at round-robin pointer `rr` and wrapping modulo `NB_SRC`.
  - Grant the first up-to-`NR_PORTS` requesting sources.
  - Assign them to ports 0,1,… in scan order.
  - Each source receives at most one grant per cycle.
  - Unused ports drive `wb_valid_o=0` and `wb_o='0`.
- Pop: every granted FIFO pops at the edge. Push and pop on the same FIFO in the same cycle leave the count unchanged.
- `rr` update: when at least one grant occurs, `rr` moves to (last granted source + 1) mod `NB_SRC`; otherwise it holds.
- Flush:
  - `flush_i=1` zeroes all counts and pointers and sets `rr=0` at the edge.
  - Pushes in that cycle are discarded.
  - Outputs in the flush cycle still reflect the pre-flush heads.
- Ordering: results from one source are written back in acceptance order. No ordering is guaranteed across sources.

## Timing
- Reset (`rstn=0`, asynchronous):
  - All counts and pointers are 0 and `rr=0`.
  - `src_ready_o` = all-ones, provided `DEPTH≥1`.
  - `wb_valid_o=0`, `wb_o='0`, `completion_o='0`.
- Reset may assert at any point mid-operation; all buffered results are lost.
- Latency: accept at edge N → earliest `wb_valid_o` in cycle N+1.
- Throughput: `NR_PORTS` results per cycle, at most 1 per source per cycle.
- `src_ready_o` and the outputs depend only on registered state, so there is no combinational path from input to output.
- Starvation bound: a non-empty source is granted within ⌈`NB_SRC`/`NR_PORTS`⌉ cycles.

## Configuration
- `WB_ARB_BYPASS_EN` defined:
  - A source whose FIFO is empty and whose `src_valid_i` is high requests in the same cycle, using `src_i` directly.
  - It is scanned like a FIFO head.
  - If granted, the result is written back with 0-cycle latency and not stored.
  - If not granted, it is pushed normally.
  - `src_ready_o` remains `count < DEPTH` and does not depend on the grant.
- Not defined: no bypass; latency is strictly ≥1 cycle as above.

## Test plan
- Single result: source 1, id=5, one cycle of valid after reset → `wb_valid_o=2'b01`, `wb_o[0].id=5` and `completion_o[0]={id:5,valid:1}` exactly one cycle later; nothing on port 1.
- Collision: `NB_SRC=3`, `NR_PORTS=2`, all three sources valid in the same cycle with ids 1,2,3 → next cycle ports carry ids 1,2 and `rr=0→2`; the cycle after, port 0 carries id 3.
- Full/back-pressure: `DEPTH=2`, source 0 valid for 4 consecutive cycles while the other sources hold higher-priority traffic → `src_ready_o[0]` drops after 2 accepts; no result is lost or duplicated; per-source order is preserved.
- Fairness: all sources continuously valid for 30 cycles → each source is granted 20±1 times and no gap exceeds 2 cycles.
- Flush: 4 results buffered, then `flush_i` pulsed → from the next cycle `wb_valid_o=0` and `src_ready_o` is all-ones; a new result is written back normally afterwards.
- Reset mid-stream: `rstn` dropped asynchronously mid-cycle with 3 results buffered → outputs go to zero immediately; after release the FIFOs are empty.
- With `WB_ARB_BYPASS_EN`: the single-result case is written back in the same cycle.

Source files
------------

// File: rtl/wb_arb_if.sv
// Result types and the source/write-back bundle for the write-back arbiter.
// The 'slave' modport is the arbiter side and 'master' is the FU/consumer side.
package wb_arb_pkg;
    localparam int NR_WB_PORTS = 2;
    localparam int ID_W        = 4;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [31:0]     result;
    } fu_output_t;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic            valid;
    } completion_port_t;
endpackage

interface wb_arb_if
    import wb_arb_pkg::*;
#(
    parameter int NB_SRC   = 3,
    parameter int NR_PORTS = NR_WB_PORTS
);
    fu_output_t       src_i        [NB_SRC];
    logic [NB_SRC-1:0] src_valid_i;
    logic [NB_SRC-1:0] src_ready_o;
    fu_output_t       wb_o         [NR_PORTS];
    logic [NR_PORTS-1:0] wb_valid_o;
    completion_port_t completion_o [NR_PORTS];

    modport master (
        output src_i, src_valid_i,
        input  src_ready_o, wb_o, wb_valid_o, completion_o
    );

    modport slave (
        input  src_i, src_valid_i,
        output src_ready_o, wb_o, wb_valid_o, completion_o
    );
endinterface

// File: rtl/wb_arb.sv
// Per-source result FIFOs granted round-robin onto NR_PORTS write-back ports; accept->writeback 1 cycle,
// ready = FIFO not full, no back-pressure on write-back. WB_ARB_BYPASS_EN enables 0-cycle bypass of empty FIFOs.
module wb_arb
    import wb_arb_pkg::*;
#(
    parameter int NB_SRC   = 3,
    parameter int DEPTH    = 2,
    parameter int NR_PORTS = NR_WB_PORTS
) (
    input  logic     clk,
    input  logic     rstn,
    input  logic     flush_i,
    wb_arb_if.slave  bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SW = (NB_SRC > 1) ? $clog2(NB_SRC) : 1;

    fu_output_t    mem    [NB_SRC][DEPTH];
    logic [PW-1:0] rd_ptr [NB_SRC];
    logic [PW-1:0] wr_ptr [NB_SRC];
    logic [CW-1:0] cnt    [NB_SRC];
    logic [SW-1:0] rr;

    logic [NB_SRC-1:0]   req, gnt, ready, push, pop, byp;
    fu_output_t          head [NB_SRC];
    fu_output_t          wb   [NR_PORTS];
    logic [NR_PORTS-1:0] wbv;
    logic [SW-1:0]       rr_nxt;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        for (int s = 0; s < NB_SRC; s++) begin
            ready[s] = (cnt[s] < CW'(DEPTH));
`ifdef WB_ARB_BYPASS_EN
            byp[s]  = (cnt[s] == '0) && bus.src_valid_i[s];
            head[s] = byp[s] ? bus.src_i[s] : mem[s][rd_ptr[s]];
`else
            byp[s]  = 1'b0;
            head[s] = mem[s][rd_ptr[s]];
`endif
            req[s]  = (cnt[s] != '0) || byp[s];
        end
    end

    // Scan from rr; granted sources fill ports 0,1,... in scan order.
    always_comb begin
        int            n;
        logic [SW-1:0] idx;
        n      = 0;
        idx    = '0;
        gnt    = '0;
        wbv    = '0;
        rr_nxt = rr;
        for (int p = 0; p < NR_PORTS; p++) wb[p] = '0;
        for (int k = 0; k < NB_SRC; k++) begin
            idx = SW'((int'(rr) + k) % NB_SRC);
            if (req[idx] && (n < NR_PORTS)) begin
                gnt[idx] = 1'b1;
                for (int p = 0; p < NR_PORTS; p++) begin
                    if (p == n) begin
                        wb[p]  = head[idx];
                        wbv[p] = 1'b1;
                    end
                end
                rr_nxt = SW'((int'(idx) + 1) % NB_SRC);
                n      = n + 1;
            end
        end
    end

    // A bypassed grant is neither stored nor popped.
    always_comb begin
        for (int s = 0; s < NB_SRC; s++) begin
            push[s] = bus.src_valid_i[s] && ready[s] && !(byp[s] && gnt[s]);
            pop[s]  = gnt[s] && !byp[s];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr <= '0;
            for (int s = 0; s < NB_SRC; s++) begin
                cnt[s]    <= '0;
                rd_ptr[s] <= '0;
                wr_ptr[s] <= '0;
            end
        end else if (flush_i) begin
            rr <= '0;
            for (int s = 0; s < NB_SRC; s++) begin
                cnt[s]    <= '0;
                rd_ptr[s] <= '0;
                wr_ptr[s] <= '0;
            end
        end else begin
            rr <= rr_nxt;
            for (int s = 0; s < NB_SRC; s++) begin
                if (push[s]) wr_ptr[s] <= ptr_inc(wr_ptr[s]);
                if (pop[s])  rd_ptr[s] <= ptr_inc(rd_ptr[s]);
                if (push[s] && !pop[s])      cnt[s] <= cnt[s] + 1'b1;
                else if (pop[s] && !push[s]) cnt[s] <= cnt[s] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int s = 0; s < NB_SRC; s++) begin
            if (push[s]) mem[s][wr_ptr[s]] <= bus.src_i[s];
        end
    end

    assign bus.src_ready_o = ready;
    assign bus.wb_valid_o  = wbv;

    for (genvar p = 0; p < NR_PORTS; p++) begin : g_port
        assign bus.wb_o[p]               = wb[p];
        assign bus.completion_o[p].id    = wb[p].id;
        assign bus.completion_o[p].valid = wbv[p];
    end
endmodule
